fir_2x_tap_sequencer: RTL and testbench

//   Sequences the 32-tap 2x-interpolating FIR: for each accepted input sample, writes it into a
//   16-entry circular delay line and runs two polyphase passes of 16 MACs. Drives the coefficient

---
 rtl/fir_2x_tap_sequencer_if.sv | 40 ++++
 rtl/fir_2x_tap_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fir_2x_tap_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_2x_tap_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : fir_2x_tap_sequencer_if
// Brief   : Sample handshake, delay-RAM ports, tap BROM address and MAC strobes.
// Revision: 1.0 - initial release
// ============================================================================
interface fir_2x_tap_sequencer_if #(
  parameter int DATA_W     = 16,
  parameter int DLY_ADDR_W = 4,
  parameter int TAP_ADDR_W = 5
);
  logic                  clear;
  logic [DATA_W-1:0]     din;
  logic                  din_valid;
  logic                  din_ready;
  logic                  dly_wr_en;
  logic [DLY_ADDR_W-1:0] dly_wr_addr;
  logic [DATA_W-1:0]     dly_wr_data;
  logic [DLY_ADDR_W-1:0] dly_rd_addr;
  logic [TAP_ADDR_W-1:0] coef_address;
  logic                  coef_valid;
  logic                  mac_valid;
  logic                  mac_first;
  logic                  mac_last;
  logic                  mac_phase;

  // master: sample source / datapath side; slave: the sequencer
  modport master (
    output clear, din, din_valid,
    input  din_ready, dly_wr_en, dly_wr_addr, dly_wr_data, dly_rd_addr,
    input  coef_address, coef_valid, mac_valid, mac_first, mac_last, mac_phase
  );

  modport slave (
    input  clear, din, din_valid,
    output din_ready, dly_wr_en, dly_wr_addr, dly_wr_data, dly_rd_addr,
    output coef_address, coef_valid, mac_valid, mac_first, mac_last, mac_phase
  );
endinterface
`default_nettype wire

// File: rtl/fir_2x_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fir_2x_tap_sequencer
// Brief   : Per-sample write + two 16-tap polyphase passes for a 32-tap 2x FIR.
// Revision: 1.0 - initial release
// ============================================================================
module fir_2x_tap_sequencer #(
  parameter int NUM_TAPS    = 32,
  parameter int TAP_ADDR_W  = 5,
  parameter int DLY_ADDR_W  = 4,
  parameter int DATA_W      = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  fir_2x_tap_sequencer_if.slave   bus
);

  localparam int                    c_taps_per_phase = NUM_TAPS / 2;
  localparam logic [DLY_ADDR_W-1:0] c_last_k = DLY_ADDR_W'(c_taps_per_phase - 1);
  localparam logic [DLY_ADDR_W-1:0] c_one    = DLY_ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_PHASE0 = 3'd2,
    S_PHASE1 = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DLY_ADDR_W-1:0] r_k;
  logic [DLY_ADDR_W-1:0] w_k_nxt;
  logic [DLY_ADDR_W-1:0] r_wr_ptr;
  logic [DLY_ADDR_W-1:0] w_wr_ptr_nxt;
  logic [DLY_ADDR_W-1:0] r_newest;
  logic [DLY_ADDR_W-1:0] w_newest_nxt;

  logic                  w_din_ready;
  logic                  w_wr_en;
  logic [DLY_ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0]     w_wr_data;
  logic [DLY_ADDR_W-1:0] w_rd_addr;
  logic [TAP_ADDR_W-1:0] w_coef_addr;
  logic                  w_coef_valid;
  logic                  w_tap_first;
  logic                  w_tap_last;
  logic                  w_phase;

  // {valid, first, last, phase} of the tap presented on the BROM this cycle
  logic [3:0]            r_tap;
  logic [3:0]            r_mac_pipe [ROM_LATENCY];

  always_comb begin
    w_state_nxt  = r_state;
    w_k_nxt      = r_k;
    w_wr_ptr_nxt = r_wr_ptr;
    w_newest_nxt = r_newest;

    case (r_state)
      S_IDLE: begin
        if (bus.clear) begin
          w_state_nxt = S_CLEAR;
          w_k_nxt     = '0;
        end else if (bus.din_valid && bus.din_ready) begin
          w_state_nxt  = S_WRITE;
          w_newest_nxt = r_wr_ptr;
          w_wr_ptr_nxt = r_wr_ptr + c_one;
        end
      end
      S_WRITE: begin
        w_state_nxt = S_PHASE0;
        w_k_nxt     = '0;
      end
      S_PHASE0: begin
        if (r_k == c_last_k) begin
          w_state_nxt = S_PHASE1;
          w_k_nxt     = '0;
        end else begin
          w_k_nxt = r_k + c_one;
        end
      end
      S_PHASE1: begin
        if (r_k == c_last_k) begin
          w_state_nxt = S_IDLE;
          w_k_nxt     = '0;
        end else begin
          w_k_nxt = r_k + c_one;
        end
      end
      S_CLEAR: begin
        if (r_k == c_last_k) begin
          w_state_nxt  = S_IDLE;
          w_k_nxt      = '0;
          w_wr_ptr_nxt = '0;
        end else begin
          w_k_nxt = r_k + c_one;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it
    w_din_ready  = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_addr    = '0;
    w_wr_data    = '0;
    w_rd_addr    = '0;
    w_coef_addr  = '0;
    w_coef_valid = 1'b0;
    w_tap_first  = 1'b0;
    w_tap_last   = 1'b0;
    w_phase      = 1'b0;

    case (w_state_nxt)
      S_IDLE: begin
        w_din_ready = 1'b1;
      end
      S_WRITE: begin
        // WRITE is only entered from an IDLE accept, so din is the accepted sample
        w_wr_en   = 1'b1;
        w_wr_addr = w_newest_nxt;
        w_wr_data = bus.din;
      end
      S_PHASE0, S_PHASE1: begin
        w_phase      = (w_state_nxt == S_PHASE1);
        w_coef_valid = 1'b1;
        w_coef_addr  = TAP_ADDR_W'({w_k_nxt, w_phase});
        w_rd_addr    = w_newest_nxt - w_k_nxt;
        w_tap_first  = (w_k_nxt == '0);
        w_tap_last   = (w_k_nxt == c_last_k);
      end
      S_CLEAR: begin
        w_wr_en   = 1'b1;
        w_wr_addr = w_k_nxt;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state          <= S_IDLE;
      r_k              <= '0;
      r_wr_ptr         <= '0;
      r_newest         <= '0;
      r_tap            <= '0;
      bus.din_ready    <= 1'b0;
      bus.dly_wr_en    <= 1'b0;
      bus.dly_wr_addr  <= '0;
      bus.dly_wr_data  <= '0;
      bus.dly_rd_addr  <= '0;
      bus.coef_address <= '0;
      bus.coef_valid   <= 1'b0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        r_mac_pipe[i] <= '0;
      end
    end else begin
      r_state          <= w_state_nxt;
      r_k              <= w_k_nxt;
      r_wr_ptr         <= w_wr_ptr_nxt;
      r_newest         <= w_newest_nxt;
      r_tap            <= {w_coef_valid, w_tap_first, w_tap_last, w_phase};
      bus.din_ready    <= w_din_ready;
      bus.dly_wr_en    <= w_wr_en;
      bus.dly_wr_addr  <= w_wr_addr;
      bus.dly_wr_data  <= w_wr_data;
      bus.dly_rd_addr  <= w_rd_addr;
      bus.coef_address <= w_coef_addr;
      bus.coef_valid   <= w_coef_valid;
      r_mac_pipe[0]    <= r_tap;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_mac_pipe[i] <= r_mac_pipe[i-1];
      end
    end
  end

  assign bus.mac_valid = r_mac_pipe[ROM_LATENCY-1][3];
  assign bus.mac_first = r_mac_pipe[ROM_LATENCY-1][2];
  assign bus.mac_last  = r_mac_pipe[ROM_LATENCY-1][1];
  assign bus.mac_phase = r_mac_pipe[ROM_LATENCY-1][0];

endmodule
`default_nettype wire

// File: tb/tb_fir_2x_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fir_2x_tap_sequencer
// Brief   : Random stimulus, queue scoreboard and FIR-result check via RAM/BROM/MAC harness.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fir_2x_tap_sequencer;

  localparam int NUM_TAPS    = 32;
  localparam int TAP_ADDR_W  = 5;
  localparam int DLY_ADDR_W  = 4;
  localparam int DATA_W      = 16;
  localparam int ROM_LATENCY = 1;
  localparam int NEVER       = 32'h7fff_ffff;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fir_2x_tap_sequencer_if #(.DATA_W(DATA_W), .DLY_ADDR_W(DLY_ADDR_W), .TAP_ADDR_W(TAP_ADDR_W)) bus ();

  fir_2x_tap_sequencer #(
    .NUM_TAPS(NUM_TAPS), .TAP_ADDR_W(TAP_ADDR_W), .DLY_ADDR_W(DLY_ADDR_W),
    .DATA_W(DATA_W), .ROM_LATENCY(ROM_LATENCY)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  typedef struct {int cyc; int a; int b;} ev_t;
  ev_t    wq[$];
  ev_t    tq[$];
  ev_t    mq[$];
  longint yq[$];

  int cyc        = 0;
  int busy_until = NEVER;
  int n_pass     = 0;
  int n_total    = 0;

  logic [15:0] dl [16];
  int          m_wr_ptr = 0;

  function automatic int coefv(int a);
    return a * 37 - 500;
  endfunction

  function automatic logic [15:0] init_val(int i);
    return 16'(i * 1111 + 7);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Environment: delay RAM and coefficient BROM, both one cycle read latency
  logic [15:0]        ram [16];
  logic [15:0]        rd_q;
  logic signed [15:0] coef_q;
  bit                 ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (bus.dly_wr_en) begin
      ram[bus.dly_wr_addr] <= bus.dly_wr_data;
    end
    rd_q   <= ram[bus.dly_rd_addr];
    coef_q <= 16'(coefv(int'(bus.coef_address)));
  end

  // Reference model: what one accepted sample must produce, from the block's rules
  task automatic model_accept(int c, logic [15:0] x);
    int     w;
    longint y;
    w        = m_wr_ptr;
    dl[w]    = x;
    m_wr_ptr = (w + 1) % 16;
    wq.push_back('{c + 1, w, int'(x)});
    for (int p = 0; p < 2; p++) begin
      y = 0;
      for (int k = 0; k < 16; k++) begin
        tq.push_back('{c + 2 + 16 * p + k, 2 * k + p, (w - k) & 15});
        mq.push_back('{c + 3 + 16 * p + k, 0, ((k == 0) ? 4 : 0) + ((k == 15) ? 2 : 0) + p});
        y += longint'(coefv(2 * k + p)) * longint'($signed(dl[(w - k) & 15]));
      end
      yq.push_back(y);
    end
    busy_until = c + 34;
  endtask

  task automatic model_clear(int c);
    for (int k = 0; k < 16; k++) begin
      wq.push_back('{c + 1 + k, k, 0});
      dl[k] = 16'd0;
    end
    m_wr_ptr   = 0;
    busy_until = c + 17;
  endtask

  task automatic flush_model();
    wq.delete();
    tq.delete();
    mq.delete();
    yq.delete();
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit clr, output bit accepted);
    @(negedge clk);
    bus.din_valid = v;
    bus.din       = d;
    bus.clear     = clr;
    accepted      = 1'b0;
    if (rstn && cyc >= busy_until) begin
      if (clr) model_clear(cyc);
      else if (v) begin
        model_accept(cyc, d);
        accepted = 1'b1;
      end
    end
  endtask

  task automatic idle(int n);
    bit a;
    repeat (n) drive(1'b0, 16'($urandom), 1'b0, a);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn          = 1'b1;
    bus.din_valid = 1'b0;
    bus.clear     = 1'b0;
    m_wr_ptr      = 0;
    busy_until    = cyc + 1;
  endtask

  // Monitor: samples one time unit after each rising edge and scores every output
  initial begin : monitor
    longint acc;
    ev_t    e;
    acc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rstn) begin
        check("reset_outputs_zero", 64'({bus.din_ready, bus.dly_wr_en, bus.dly_wr_addr, bus.dly_wr_data,
              bus.dly_rd_addr, bus.coef_address, bus.coef_valid, bus.mac_valid, bus.mac_first,
              bus.mac_last, bus.mac_phase}), 64'd0);
      end else begin
        check("din_ready", 64'(bus.din_ready), 64'(cyc >= busy_until));

        while (wq.size() > 0 && wq[0].cyc < cyc) begin
          e = wq.pop_front();
          check("wr_missing_cycle", 64'(cyc), 64'(e.cyc));
        end
        if (bus.dly_wr_en) begin
          if (wq.size() == 0) check("wr_unexpected", {32'(cyc), 16'(bus.dly_wr_addr), bus.dly_wr_data}, 64'd0);
          else begin
            e = wq.pop_front();
            check("wr_cyc_addr_data", {32'(cyc), 16'(bus.dly_wr_addr), bus.dly_wr_data},
                  {32'(e.cyc), 16'(e.a), 16'(e.b)});
          end
        end else begin
          check("wr_idle_zero", 64'({bus.dly_wr_addr, bus.dly_wr_data}), 64'd0);
        end

        while (tq.size() > 0 && tq[0].cyc < cyc) begin
          e = tq.pop_front();
          check("tap_missing_cycle", 64'(cyc), 64'(e.cyc));
        end
        if (bus.coef_valid) begin
          if (tq.size() == 0) check("tap_unexpected", {32'(cyc), 16'(bus.coef_address), 16'(bus.dly_rd_addr)}, 64'd0);
          else begin
            e = tq.pop_front();
            check("tap_cyc_coef_rd", {32'(cyc), 16'(bus.coef_address), 16'(bus.dly_rd_addr)},
                  {32'(e.cyc), 16'(e.a), 16'(e.b)});
          end
        end else begin
          check("tap_idle_zero", 64'({bus.coef_address, bus.dly_rd_addr}), 64'd0);
        end

        while (mq.size() > 0 && mq[0].cyc < cyc) begin
          e = mq.pop_front();
          check("mac_missing_cycle", 64'(cyc), 64'(e.cyc));
        end
        if (bus.mac_valid) begin
          if (mq.size() == 0) check("mac_unexpected", {32'(cyc), 32'({bus.mac_first, bus.mac_last, bus.mac_phase})}, 64'd0);
          else begin
            e = mq.pop_front();
            check("mac_cyc_first_last_phase", {32'(cyc), 32'({bus.mac_first, bus.mac_last, bus.mac_phase})},
                  {32'(e.cyc), 32'(e.b)});
          end
          acc = (bus.mac_first ? 64'sd0 : acc) + longint'(coef_q) * longint'($signed(rd_q));
          if (bus.mac_last) begin
            if (yq.size() == 0) check("mac_result_unexpected", acc, 64'd0);
            else check("mac_result", acc, yq.pop_front());
          end
        end else begin
          check("mac_idle_zero", 64'({bus.mac_first, bus.mac_last, bus.mac_phase}), 64'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit          a;
    int          nacc;
    int          c;
    logic [15:0] d;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.clear     = 1'b0;
    for (int i = 0; i < 16; i++) dl[i] = init_val(i);

    // Reset held five cycles, then idle
    idle(5);
    release_reset();
    idle(4);

    // Single directed sample
    drive(1'b1, 16'h1234, 1'b0, a);
    idle(40);

    // clear and din_valid together: clear wins, then a sample lands at address 0
    drive(1'b1, 16'hBEEF, 1'b1, a);
    idle(20);
    drive(1'b1, 16'($urandom), 1'b0, a);
    idle(40);

    // 17 samples back-to-back with din_valid held high (delay line wraps)
    nacc = 0;
    d    = 16'($urandom);
    while (nacc < 17) begin
      drive(1'b1, d, 1'b0, a);
      if (a) begin
        nacc++;
        d = 16'($urandom);
      end
    end
    idle(40);

    // Random traffic with occasional clear requests
    repeat (600) drive($urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 39) == 0, a);
    while (cyc < busy_until) idle(1);
    idle(2);

    // Asynchronous reset at k=7 of PHASE1
    drive(1'b1, 16'($urandom), 1'b0, a);
    c = cyc;
    idle(24);
    @(negedge clk);
    check("pre_reset_phase1_k7", 64'({bus.coef_valid, bus.coef_address, bus.mac_valid}),
          64'({1'b1, 5'd15, 1'b1}));
    rstn          = 1'b0;
    bus.din_valid = 1'b0;
    bus.clear     = 1'b0;
    flush_model();
    busy_until    = NEVER;
    #1;
    check("async_reset_drop", 64'({bus.coef_valid, bus.mac_valid, bus.din_ready}), 64'd0);
    if (cyc != c + 25) check("reset_point_cycle", 64'(cyc), 64'(c + 25));
    idle(3);
    release_reset();
    idle(2);
    drive(1'b1, 16'($urandom), 1'b0, a);
    idle(40);

    check("scoreboard_drained", 64'(wq.size() + tq.size() + mq.size() + yq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
